turbo_puncture: RTL and testbench

//  Parametrised puncturer for the turbo encoder output stage. Each accepted input symbol

---
 rtl/turbo_pkg.sv | 28 ++
 rtl/turbo_puncture_if.sv | 34 +++
 rtl/turbo_punct_sel.sv | 38 +++
 rtl/turbo_puncture.sv | 182 ++++++++++++++++++
 tb/tb_turbo_puncture.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_pkg
//  Description : Shared definitions for the turbo puncturer: FSM state
//                encoding, default geometry and selector index sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package turbo_pkg;

    localparam int DEF_DATA_W  = 4;
    localparam int DEF_NUM_PAR = 2;
    localparam int DEF_PERIOD  = 2;
    localparam int DEF_LEN_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Width of an index addressing one of (1 + num_par) words.
    function automatic int sel_width(input int num_par);
        return (num_par > 0) ? $clog2(num_par + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_puncture_if.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_puncture_if
//  Description : Symbol-in / word-out valid-ready streams of the puncturer.
//                master : upstream encoder + downstream mapper side
//                slave  : puncturer side
//  Ports       : in_valid/in_ready/in_sys/in_par   - input symbol stream
//                out_valid/out_ready/out_data/out_last - output word stream
//  Revision    : 1.0 - initial release
// ============================================================================
interface turbo_puncture_if #(
    parameter int DATA_W  = 4,
    parameter int NUM_PAR = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           in_sys;
    logic [NUM_PAR*DATA_W-1:0]   in_par;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_data;
    logic                        out_last;

    modport master (
        output in_valid, in_sys, in_par, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_sys, in_par, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/turbo_punct_sel.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_punct_sel
//  Description : Combinational lowest-set-bit priority selector over the
//                keep mask (bit0 = systematic, bit1.. = parity channels).
//  Ports       : mask     in  - pending keep mask
//                idx      out - index of lowest set bit (0 when none)
//                any      out - at least one bit set
//                only_one out - exactly one bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module turbo_punct_sel
    import turbo_pkg::*;
#(
    parameter int NUM_PAR = DEF_NUM_PAR,
    parameter int SEL_W   = sel_width(NUM_PAR)
) (
    input  wire logic [NUM_PAR:0]  mask,
    output logic      [SEL_W-1:0]  idx,
    output logic                   any,
    output logic                   only_one
);
    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = NUM_PAR; i >= 0; i--) begin
            if (mask[i]) begin
                idx = SEL_W'(i);
            end
        end
    end

    assign any      = |mask;
    // Clearing the lowest set bit leaves zero only for a one-hot mask.
    assign only_one = any && ((mask & (mask - 1'b1)) == '0);

endmodule
`default_nettype wire

// File: rtl/turbo_puncture.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_puncture
//  Description : Run-time periodic puncturer for the turbo encoder output.
//                Accepts one symbol (systematic + NUM_PAR parity words), emits
//                the kept words one per beat, flags the last word of a frame.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                start, frame_len, pattern,
//                sys_keep, punct_en         - frame configuration (latched)
//                bus                        - symbol-in / word-out streams
//                frame_done                 - frame complete, held to next start
//  Revision    : 1.0 - initial release
// ============================================================================
module turbo_puncture
    import turbo_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_PAR = DEF_NUM_PAR,
    parameter int PERIOD  = DEF_PERIOD,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    input  wire logic                        start,
    input  wire logic [LEN_W-1:0]            frame_len,
    input  wire logic [NUM_PAR*PERIOD-1:0]   pattern,
    input  wire logic                        sys_keep,
    input  wire logic                        punct_en,
    turbo_puncture_if.slave                  bus,
    output logic                             frame_done
);
    localparam int MASK_W = NUM_PAR + 1;
    localparam int SEL_W  = sel_width(NUM_PAR);
    localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    state_t                       r_state, w_state_nxt;
    logic [PH_W-1:0]              r_phase;
    logic [LEN_W-1:0]             r_sym_cnt;
    logic [LEN_W-1:0]             r_len;
    logic [NUM_PAR*PERIOD-1:0]    r_pattern;
    logic                         r_sys_keep;
    logic                         r_punct_en;
    logic [MASK_W-1:0]            r_mask;
    logic [MASK_W*DATA_W-1:0]     r_words;   // {par[NUM_PAR-1..0], sys}

    logic [NUM_PAR-1:0]           w_par_keep;
    logic [MASK_W-1:0]            w_acc_mask;
    logic [SEL_W-1:0]             w_idx;
    logic                         w_any;
    logic                         w_only;
    logic                         w_last_sym;
    logic                         w_start_take;
    logic                         w_in_fire;
    logic                         w_out_fire;
    logic                         w_sym_end;
    logic [DATA_W-1:0]            w_word;

    // Parity keep bits for the current phase; all kept when puncturing is off.
    always_comb begin
        w_par_keep = '1;
        if (r_punct_en) begin
            w_par_keep = '0;
            for (int ph = 0; ph < PERIOD; ph++) begin
                if (r_phase == PH_W'(ph)) begin
                    w_par_keep = r_pattern[ph*NUM_PAR +: NUM_PAR];
                end
            end
        end
    end

    assign w_acc_mask = {w_par_keep, r_sys_keep};

    turbo_punct_sel #(
        .NUM_PAR (NUM_PAR),
        .SEL_W   (SEL_W)
    ) u_sel (
        .mask     (r_mask),
        .idx      (w_idx),
        .any      (w_any),
        .only_one (w_only)
    );

    always_comb begin
        w_word = '0;
        for (int w = 0; w < MASK_W; w++) begin
            if (w_idx == SEL_W'(w)) begin
                w_word = r_words[w*DATA_W +: DATA_W];
            end
        end
    end

    assign w_last_sym   = (r_sym_cnt == r_len - 1'b1);
    assign w_start_take = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_in_fire    = (r_state == ST_ACCEPT) && bus.in_valid;
    assign w_out_fire   = (r_state == ST_EMIT) && bus.out_ready && w_any;
    // A symbol finishes either when fully punctured on arrival or when its
    // final kept word is taken downstream.
    assign w_sym_end    = (w_in_fire && (w_acc_mask == '0)) || (w_out_fire && w_only);

    // Next state and stream outputs
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        frame_done    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                frame_done = (r_state == ST_DONE);
                if (start) begin
                    w_state_nxt = (frame_len == '0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (w_acc_mask == '0) begin
                        w_state_nxt = w_last_sym ? ST_DONE : ST_ACCEPT;
                    end else begin
                        w_state_nxt = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = w_word;
                bus.out_last  = w_only && w_last_sym;
                if (w_out_fire && w_only) begin
                    w_state_nxt = w_last_sym ? ST_DONE : ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Configuration latches, counters and holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_sym_cnt  <= '0;
            r_len      <= '0;
            r_pattern  <= '0;
            r_sys_keep <= 1'b0;
            r_punct_en <= 1'b0;
            r_mask     <= '0;
            r_words    <= '0;
        end else begin
            if (w_start_take) begin
                r_len      <= frame_len;
                r_pattern  <= pattern;
                r_sys_keep <= sys_keep;
                r_punct_en <= punct_en;
                r_phase    <= '0;
                r_sym_cnt  <= '0;
            end else if (w_sym_end) begin
                r_phase <= (r_phase == PH_W'(PERIOD - 1)) ? '0 : r_phase + 1'b1;
                // Hold at frame_len-1 on the final symbol.
                if (!w_last_sym) begin
                    r_sym_cnt <= r_sym_cnt + 1'b1;
                end
            end

            if (w_in_fire) begin
                r_words <= {bus.in_par, bus.in_sys};
                r_mask  <= w_acc_mask;
            end else if (w_out_fire) begin
                r_mask <= r_mask & (r_mask - 1'b1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_turbo_puncture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turbo_puncture
//  Description : Self-checking bench for turbo_puncture. Symbol i carries
//                sys = 1+i, par0 = 5+i, par1 = 9+i. Frame cases come from a
//                table of config + expected word stream; zero-length frame
//                and reset handling are hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turbo_puncture;
    import turbo_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [11:0] frame_len = '0;
    logic [3:0]  pattern   = '0;
    logic        sys_keep  = 1'b0;
    logic        punct_en  = 1'b0;
    logic        frame_done;

    turbo_puncture_if #(.DATA_W(4), .NUM_PAR(2)) bif ();

    turbo_puncture #(
        .DATA_W  (4),
        .NUM_PAR (2),
        .PERIOD  (2),
        .LEN_W   (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_len  (frame_len),
        .pattern    (pattern),
        .sys_keep   (sys_keep),
        .punct_en   (punct_en),
        .bus        (bif.slave),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Downstream ready: constant 1, or the repeating 1-0-0-1 stall pattern
    bit         stall_mode = 1'b0;
    logic [3:0] rdy_seq    = 4'b1001;
    int         rk         = 0;

    always @(posedge clk) begin
        #1;
        if (stall_mode) begin
            bif.out_ready = rdy_seq[rk];
            rk = (rk + 1) % 4;
        end else begin
            bif.out_ready = 1'b1;
        end
    end

    // Output monitor: collects accepted words and checks stall stability
    logic [3:0] got_data[$];
    logic       got_last[$];
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data  = '0;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 48'(bif.out_valid), 48'd1);
                chk("stall_data",  48'(bif.out_data),  48'(prev_data));
                chk("stall_last",  48'(bif.out_last),  48'(prev_last));
            end
            if (!bif.out_valid) begin
                chk("idle_data_last", 48'({bif.out_data, bif.out_last}), 48'd0);
            end
            if (bif.out_valid && bif.out_ready) begin
                got_data.push_back(bif.out_data);
                got_last.push_back(bif.out_last);
            end
            prev_stall = bif.out_valid && !bif.out_ready;
            prev_data  = bif.out_data;
            prev_last  = bif.out_last;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   48'(bif.in_ready),  48'd0);
        chk({tag, "_out_valid"},  48'(bif.out_valid), 48'd0);
        chk({tag, "_out_data"},   48'(bif.out_data),  48'd0);
        chk({tag, "_out_last"},   48'(bif.out_last),  48'd0);
        chk({tag, "_frame_done"}, 48'(frame_done),    48'd0);
    endtask

    typedef struct {
        logic [11:0] len;
        logic [3:0]  pat;
        logic        sk;
        logic        pe;
        bit          stall;
        int          abort_word;   // 0 = none, else reset while this word is shown
        bit          midstart;
        bit          lat1;         // out_valid expected right after first handshake
        int          nexp;
        int          last_idx;
        logic [47:0] words;        // expected word k at [k*4 +: 4]
    } tc_t;

    tc_t tcs[6];

    task automatic run_case(input tc_t tc, input int id);
        int guard;
        bit aborted;
        bit timeout;
        aborted = 1'b0;
        timeout = 1'b0;
        got_data.delete();
        got_last.delete();
        stall_mode = tc.stall;
        rk = 0;

        frame_len = tc.len;
        pattern   = tc.pat;
        sys_keep  = tc.sk;
        punct_en  = tc.pe;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config afterwards: the latched copy must be used.
        frame_len = 12'd0;
        pattern   = 4'hF;
        sys_keep  = 1'b0;
        punct_en  = 1'b0;

        for (int i = 0; i < int'(tc.len); i++) begin
            if (tc.midstart && i == 2) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            bif.in_valid = 1'b1;
            bif.in_sys   = 4'(1 + i);
            bif.in_par   = {4'(9 + i), 4'(5 + i)};
            guard = 0;
            while (!bif.in_ready && !aborted && !timeout) begin
                if (tc.abort_word > 0 && got_data.size() == tc.abort_word - 1 && bif.out_valid) begin
                    rst_n   = 1'b0;
                    aborted = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    guard++;
                    if (guard > 100) begin
                        chk($sformatf("case%0d_in_ready_timeout", id), 48'd0, 48'd1);
                        timeout = 1'b1;
                    end
                end
            end
            if (aborted || timeout) break;
            @(posedge clk); #1;
            bif.in_valid = 1'b0;
            if (i == 0) begin
                chk($sformatf("case%0d_first_latency", id), 48'(bif.out_valid), 48'(tc.lat1));
            end
        end
        bif.in_valid = 1'b0;

        if (aborted) begin
            #1;
            chk_reset_outputs($sformatf("case%0d_abort", id));
            chk($sformatf("case%0d_words_before_abort", id), 48'(got_data.size()), 48'(tc.nexp));
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end else begin
            guard = 0;
            while (!frame_done && guard <= 100) begin
                @(posedge clk); #1;
                guard++;
            end
            chk($sformatf("case%0d_frame_done", id), 48'(frame_done),    48'd1);
            chk($sformatf("case%0d_done_in_rdy", id), 48'(bif.in_ready),  48'd0);
            chk($sformatf("case%0d_done_valid", id),  48'(bif.out_valid), 48'd0);
            chk($sformatf("case%0d_word_count", id),  48'(got_data.size()), 48'(tc.nexp));
            for (int k = 0; k < tc.nexp && k < got_data.size(); k++) begin
                chk($sformatf("case%0d_word%0d_data", id, k), 48'(got_data[k]), 48'(tc.words[k*4 +: 4]));
                chk($sformatf("case%0d_word%0d_last", id, k), 48'(got_last[k]), 48'(k == tc.last_idx));
            end
        end
        stall_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_sys    = '0;
        bif.in_par    = '0;
        bif.out_ready = 1'b1;

        //            len    pat   sk pe stl abort mid lat nexp last words
        tcs[0] = '{12'd4, 4'b1001, 1, 1, 0, 0, 0, 1,  8,  7, 48'h0000_C473_A251}; // punctured
        tcs[1] = '{12'd4, 4'b1001, 1, 0, 0, 0, 0, 1, 12, 11, 48'hC84B_73A6_2951}; // unpunctured
        tcs[2] = '{12'd3, 4'b0000, 0, 1, 0, 0, 0, 0,  0, -1, 48'h0};              // all punctured
        tcs[3] = '{12'd4, 4'b1001, 1, 1, 1, 0, 0, 1,  8,  7, 48'h0000_C473_A251}; // back-pressure
        tcs[4] = '{12'd4, 4'b1001, 1, 1, 0, 3, 0, 1,  2, -1, 48'h0000_0000_0051}; // reset mid-frame
        tcs[5] = '{12'd4, 4'b1001, 1, 1, 0, 0, 1, 1,  8,  7, 48'h0000_C473_A251}; // ignored start

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 48'(bif.in_ready), 48'd0);

        // Zero-length frame from IDLE: DONE next cycle, never ready
        frame_len = 12'd0;
        pattern   = 4'b1001;
        sys_keep  = 1'b1;
        punct_en  = 1'b1;
        bif.in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_frame_done", 48'(frame_done), 48'd1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("len0_in_ready_c%0d", c), 48'(bif.in_ready), 48'd0);
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_case(tcs[t], t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
